pulse_window_counter: RTL

Front-end pulse acquisition stage that feeds the BPM monitor. Synchronises a raw asynchronous heartbeat pulse, detects rising edges, rejects re-triggers with a refractory interval, and counts accepted beats over a fixed measurement window (10 s by default). At each window close it presents a saturated 8-bit pulse_count plus a one-cycle valid strobe. The BPM stage turns that count into BPM by multiplying by 6.

---
 rtl/pulse_window_counter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pulse_window_counter.sv
// Synchronises a raw heartbeat pulse, gates re-triggers with a refractory
// interval and reports accepted beats per fixed window (saturating 8-bit).
module pulse_window_counter #(
  parameter int CLK_DIV    = 1000,
  parameter int WINDOW_MS  = 10000,
  parameter int REFRACT_MS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pulse_in,
  output logic [7:0] pulse_count,
  output logic       count_valid,
  output logic       overflow,
  output logic       window_busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MW = (WINDOW_MS > 1) ? $clog2(WINDOW_MS) : 1;
  localparam int RW = (REFRACT_MS > 0) ? $clog2(REFRACT_MS + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [MW-1:0] MS_LAST    = MW'(WINDOW_MS - 1);
  localparam logic [RW-1:0] REFR_LOAD  = RW'(REFRACT_MS);

  typedef enum logic {IDLE, RUN} main_state_t;
  typedef enum logic {READY, REFRACT} pulse_state_t;

  main_state_t  state, state_nxt;
  pulse_state_t pstate, pstate_nxt;

  logic          s1, s2, s3;
  logic          pulse_edge;
  logic [PW-1:0] presc;
  logic [MW-1:0] ms_cnt;
  logic [RW-1:0] refr_cnt, refr_nxt;
  logic [7:0]    acc, acc_next;
  logic          sat, sat_next;
  logic          run_active, stopping, tick, close, accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse_edge = s2 & ~s3;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dropping enable pre-empts a coincident window close.
  assign run_active = (state == RUN) && enable;
  assign stopping   = (state == RUN) && !enable;
  assign tick       = run_active && (presc == PRESC_LAST);
  assign close      = tick && (ms_cnt == MS_LAST);
  assign accept     = pulse_edge && (state == RUN) && (pstate == READY);
  assign acc_next   = (acc == 8'hFF) ? acc : acc + {7'd0, accept};
  assign sat_next   = sat | ((acc == 8'hFF) & accept);

  always_comb begin
    pstate_nxt = pstate;
    refr_nxt   = refr_cnt;
    if (stopping) begin
      pstate_nxt = READY;
      refr_nxt   = '0;
    end else begin
      case (pstate)
        READY: begin
          if (accept && (REFRACT_MS != 0)) begin
            pstate_nxt = REFRACT;
            refr_nxt   = REFR_LOAD;
          end
        end
        REFRACT: begin
          if (tick) begin
            refr_nxt = refr_cnt - 1'b1;
            if (refr_cnt == RW'(1)) pstate_nxt = READY;
          end
        end
        default: pstate_nxt = READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pstate   <= READY;
      refr_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pstate   <= pstate_nxt;
      refr_cnt <= refr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc       <= '0;
      ms_cnt      <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      pulse_count <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else if (run_active) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) ms_cnt <= close ? '0 : ms_cnt + 1'b1;
      if (close) begin
        pulse_count <= acc_next;
        overflow    <= sat_next;
        acc         <= '0;
        sat         <= 1'b0;
        count_valid <= 1'b1;
      end else begin
        acc         <= acc_next;
        sat         <= sat_next;
        count_valid <= 1'b0;
      end
    end else begin
      presc       <= '0;
      ms_cnt      <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      count_valid <= 1'b0;
    end
  end

  assign window_busy = (state == RUN);

endmodule
